// File: rtl/nios2_oci_debug_mem.sv
// OCI monitor RAM with MonAReg/MonDReg, arbitrating host JTAG ops against CPU Avalon-MM slave accesses.
// Optional `OCI_MEM_WRITE_PROTECT_EN: CPU writes issued with debugaccess=0 complete but are discarded.
module nios2_oci_debug_mem #(
  parameter int RAM_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [37:0]           jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic                  take_no_action_ocimem_a,
  input  logic [RAM_ADDR_W:0]   address,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic [3:0]            byteenable,
  input  logic                  debugaccess,
  output logic [31:0]           readdata,
  output logic                  waitrequest,
  output logic [31:0]           MonDReg,
  output logic                  monitor_ready,
  output logic                  monitor_error,
  output logic                  monitor_go
);

  typedef enum logic [1:0] {J_IDLE, J_WR, J_RD_WAIT, J_RD_CAPT} jstate_t;
  typedef enum logic [1:0] {C_IDLE, C_ACC, C_DONE} cstate_t;

  jstate_t                 jstate, jstate_nxt;
  cstate_t                 cstate, cstate_nxt;
  logic [RAM_ADDR_W-1:0]   mon_areg;
  logic [RAM_ADDR_W-1:0]   wr_addr;
  logic [RAM_ADDR_W-1:0]   ram_addr;
  logic [31:0]             mem [0:(2**RAM_ADDR_W)-1];
  logic [31:0]             ram_q;
  logic [31:0]             ctrl_rd_q;
  logic                    ctrl_sel_q;
  logic                    jtag_a, jtag_b, jtag_rd, jtag_port;
  logic                    cpu_req, cpu_ctrl, cpu_wr_ok, cpu_ram_go, cpu_ctrl_wr, host_clr;
  logic                    unused;

`ifdef OCI_MEM_WRITE_PROTECT_EN
  assign cpu_wr_ok = write & debugaccess;
  assign unused    = ^{jdo[37:36], jdo[1:0]};
`else
  assign cpu_wr_ok = write;
  assign unused    = ^{jdo[37:36], jdo[1:0], debugaccess};
`endif

  // ocimem_b is also accepted in J_WR: the pending word is written from registers on the same edge.
  assign jtag_a    = take_action_ocimem_a;
  assign jtag_b    = take_action_ocimem_b & ~jtag_a & ((jstate == J_IDLE) | (jstate == J_WR));
  assign jtag_rd   = take_no_action_ocimem_a & ~jtag_a & ~take_action_ocimem_b & (jstate == J_IDLE);
  assign jtag_port = jtag_b | jtag_rd | (jstate != J_IDLE);

  assign cpu_req     = chipselect & (read | write);
  assign cpu_ctrl    = address[RAM_ADDR_W];
  assign cpu_ram_go  = (cstate == C_ACC) & ~cpu_ctrl & ~jtag_port;
  assign cpu_ctrl_wr = (cstate == C_ACC) & cpu_ctrl & cpu_wr_ok;
  assign host_clr    = jtag_a & jdo[34];
  assign ram_addr    = jtag_rd ? mon_areg : address[RAM_ADDR_W-1:0];

  always_comb begin
    jstate_nxt = jstate;
    unique case (jstate)
      J_IDLE:    if (jtag_b) jstate_nxt = J_WR;
                 else if (jtag_rd) jstate_nxt = J_RD_WAIT;
      J_WR:      if (!jtag_b) jstate_nxt = J_IDLE;
      J_RD_WAIT: jstate_nxt = J_RD_CAPT;
      J_RD_CAPT: jstate_nxt = J_IDLE;
      default:   jstate_nxt = J_IDLE;
    endcase
  end

  always_comb begin
    cstate_nxt  = cstate;
    waitrequest = 1'b1;
    unique case (cstate)
      C_IDLE:  if (cpu_req && !jtag_port) cstate_nxt = C_ACC;
      C_ACC:   if (cpu_ctrl || !jtag_port) cstate_nxt = C_DONE;
      C_DONE: begin
        waitrequest = 1'b0;
        cstate_nxt  = C_IDLE;
      end
      default: cstate_nxt = C_IDLE;
    endcase
  end

  assign readdata = ((cstate == C_DONE) && read) ? (ctrl_sel_q ? ctrl_rd_q : ram_q) : 32'h0;

  // Single-port RAM, read-first, registered output; contents are not reset.
  always_ff @(posedge clk) begin
    if (jstate == J_WR) begin
      mem[wr_addr] <= MonDReg;
    end else if (cpu_ram_go && cpu_wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) mem[ram_addr][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
    ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      jstate        <= J_IDLE;
      cstate        <= C_IDLE;
      mon_areg      <= '0;
      wr_addr       <= '0;
      MonDReg       <= 32'h0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      monitor_go    <= 1'b0;
      ctrl_sel_q    <= 1'b0;
      ctrl_rd_q     <= 32'h0;
    end else begin
      jstate <= jstate_nxt;
      cstate <= cstate_nxt;

      if (jtag_a) mon_areg <= jdo[RAM_ADDR_W+1:2];
      else if (jtag_b || jtag_rd) mon_areg <= mon_areg + 1'b1;

      if (jtag_b) begin
        MonDReg <= jdo[34:3];
        wr_addr <= mon_areg;
      end else if (jstate == J_RD_WAIT) begin
        MonDReg <= ram_q;
      end

      // Host clear beats a coincident CPU set.
      monitor_ready <= (monitor_ready | (cpu_ctrl_wr & writedata[0])) & ~host_clr;
      monitor_error <= (monitor_error | (cpu_ctrl_wr & writedata[1])) & ~host_clr;
      if (jtag_a && jdo[35]) monitor_go <= 1'b1;
      else if (cpu_ctrl_wr && writedata[2]) monitor_go <= 1'b0;

      if (cstate == C_ACC) begin
        ctrl_sel_q <= cpu_ctrl;
        ctrl_rd_q  <= {29'b0, monitor_go, monitor_error, monitor_ready};
      end
    end
  end

endmodule

// File: tb/tb_nios2_oci_debug_mem.sv
// Directed bench for nios2_oci_debug_mem: JTAG ops, CPU slave accesses, CTRL register, arbitration.
module tb_nios2_oci_debug_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [8:0]  address;
  logic        chipselect, read, write, debugaccess;
  logic [31:0] writedata, readdata, MonDReg;
  logic [3:0]  byteenable;
  logic        waitrequest, monitor_ready, monitor_error, monitor_go;

  int checks = 0;
  int errors = 0;

  nios2_oci_debug_mem #(.RAM_ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .address(address), .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .debugaccess(debugaccess),
    .readdata(readdata), .waitrequest(waitrequest), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error), .monitor_go(monitor_go)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] jaddr(input logic [7:0] a, input logic clr, input logic go);
    logic [37:0] j;
    j = '0;
    j[9:2] = a;
    j[34] = clr;
    j[35] = go;
    return j;
  endfunction

  function automatic logic [37:0] jdata(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic jtag_op(input logic a, input logic b, input logic na, input logic [37:0] d);
    jdo = d;
    take_action_ocimem_a = a;
    take_action_ocimem_b = b;
    take_no_action_ocimem_a = na;
    @(posedge clk);
    #1;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic cpu_access(input logic wr, input logic [8:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic da,
                            output logic [31:0] rdata, output int cycles);
    logic done;
    done = 1'b0;
    cycles = 0;
    rdata = 'x;
    address = a; writedata = d; byteenable = be; debugaccess = da;
    chipselect = 1'b1; read = ~wr; write = wr;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cycles++;
      if (!waitrequest) begin
        rdata = readdata;
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL cpu_timeout: waitrequest still %b after %0d cycles, required 0", waitrequest, cycles);
    end
    @(posedge clk);
    #1;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({MonDReg, readdata, waitrequest, monitor_ready, monitor_error, monitor_go, dut.mon_areg}
        !== {32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: MonDReg=%h rd=%h wait=%b rdy=%b err=%b go=%b areg=%h", MonDReg,
               readdata, waitrequest, monitor_ready, monitor_error, monitor_go, dut.mon_areg);
    end
  endtask

  task automatic test_addr_load();
    jtag_op(1, 0, 0, jaddr(8'h10, 0, 0));
    checks++;
    if ({dut.mon_areg, monitor_ready, monitor_error, monitor_go} !== {8'h10, 3'b000}) begin
      errors++;
      $display("FAIL addr_load: areg=%h flags=%b%b%b, required 10 000", dut.mon_areg,
               monitor_ready, monitor_error, monitor_go);
    end
  endtask

  task automatic test_jtag_rw();
    jtag_op(0, 1, 0, jdata(32'hDEADBEEF));
    jtag_op(0, 1, 0, jdata(32'hCAFEF00D));
    checks++;
    if ({MonDReg, dut.mon_areg} !== {32'hCAFEF00D, 8'h12}) begin
      errors++;
      $display("FAIL jtag_write: MonDReg=%h areg=%h, required cafef00d 12", MonDReg, dut.mon_areg);
    end
    jtag_op(1, 0, 0, jaddr(8'h10, 0, 0));
    jtag_op(0, 0, 1, '0);
    checks++;
    if ({MonDReg, dut.mon_areg} !== {32'hCAFEF00D, 8'h11}) begin
      errors++;
      $display("FAIL jtag_read_early: MonDReg=%h areg=%h, required cafef00d 11", MonDReg, dut.mon_areg);
    end
    idle(1);
    checks++;
    if (MonDReg !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL jtag_read_lat2: MonDReg=%h, required deadbeef", MonDReg);
    end
    // FSM is in RD_CAPT here, so this pulse must be ignored.
    jtag_op(0, 0, 1, '0);
    idle(2);
    checks++;
    if ({MonDReg, dut.mon_areg} !== {32'hDEADBEEF, 8'h11}) begin
      errors++;
      $display("FAIL read_dropped: MonDReg=%h areg=%h, required deadbeef 11", MonDReg, dut.mon_areg);
    end
    jtag_op(0, 0, 1, '0);
    idle(1);
    checks++;
    if ({MonDReg, dut.mon_areg} !== {32'hCAFEF00D, 8'h12}) begin
      errors++;
      $display("FAIL jtag_read_next: MonDReg=%h areg=%h, required cafef00d 12", MonDReg, dut.mon_areg);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    int cyc;
    jtag_op(1, 0, 0, jaddr(8'hFF, 0, 0));
    jtag_op(0, 1, 0, jdata(32'h0BADF00D));
    checks++;
    if (dut.mon_areg !== 8'h00) begin
      errors++;
      $display("FAIL areg_wrap: areg=%h, required 00", dut.mon_areg);
    end
    idle(1);
    cpu_access(0, 9'h0FF, '0, 4'hF, 1, rd, cyc);
    checks++;
    if ({rd, cyc[7:0]} !== {32'h0BADF00D, 8'd3}) begin
      errors++;
      $display("FAIL ram_ff_read: data=%h cycles=%0d, required 0badf00d 3", rd, cyc);
    end
  endtask

  task automatic test_priority();
    jtag_op(1, 1, 0, jaddr(8'h40, 0, 0));
    checks++;
    if ({MonDReg, dut.mon_areg} !== {32'h0BADF00D, 8'h40}) begin
      errors++;
      $display("FAIL prio_a_over_b: MonDReg=%h areg=%h, required 0badf00d 40", MonDReg, dut.mon_areg);
    end
    jtag_op(1, 0, 1, jaddr(8'h41, 0, 0));
    idle(2);
    checks++;
    if ({MonDReg, dut.mon_areg} !== {32'h0BADF00D, 8'h41}) begin
      errors++;
      $display("FAIL prio_a_over_rd: MonDReg=%h areg=%h, required 0badf00d 41", MonDReg, dut.mon_areg);
    end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd;
    int cyc;
    cpu_access(1, 9'h100, 32'h3, 4'h0, 1, rd, cyc);
    checks++;
    if ({monitor_ready, monitor_error, monitor_go, cyc[7:0]} !== {3'b110, 8'd3}) begin
      errors++;
      $display("FAIL ctrl_set: rdy/err/go=%b%b%b cycles=%0d, required 110 3", monitor_ready,
               monitor_error, monitor_go, cyc);
    end
    jtag_op(1, 0, 0, jaddr(8'h00, 0, 1));
    cpu_access(0, 9'h1A5, '0, 4'h0, 1, rd, cyc);
    checks++;
    if (rd !== 32'h7) begin
      errors++;
      $display("FAIL ctrl_read: data=%h, required 00000007", rd);
    end
    cpu_access(1, 9'h100, 32'h4, 4'h0, 1, rd, cyc);
    jtag_op(1, 0, 0, jaddr(8'h00, 1, 0));
    checks++;
    if ({monitor_ready, monitor_error, monitor_go} !== 3'b000) begin
      errors++;
      $display("FAIL ctrl_clear: rdy/err/go=%b%b%b, required 000", monitor_ready, monitor_error, monitor_go);
    end
    // CPU set lands on the same edge as a host clear.
    address = 9'h100; writedata = 32'h3; byteenable = 4'h0; debugaccess = 1'b1;
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    idle(1);
    jtag_op(1, 0, 0, jaddr(8'h00, 1, 0));
    checks++;
    if ({waitrequest, monitor_ready, monitor_error} !== 3'b000) begin
      errors++;
      $display("FAIL clear_wins: wait=%b rdy=%b err=%b, required 0 0 0", waitrequest, monitor_ready, monitor_error);
    end
    idle(1);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic test_byteenable();
    logic [31:0] rd;
    int cyc;
    cpu_access(1, 9'h020, 32'h11223344, 4'hF, 1, rd, cyc);
    cpu_access(1, 9'h020, 32'hAABBCCDD, 4'b0101, 1, rd, cyc);
    cpu_access(0, 9'h020, '0, 4'hF, 1, rd, cyc);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byteenable: data=%h, required 11bb33dd", rd);
    end
    jtag_op(1, 0, 0, jaddr(8'h20, 0, 0));
    jtag_op(0, 0, 1, '0);
    idle(1);
    checks++;
    if (MonDReg !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL jtag_sees_cpu_write: MonDReg=%h, required 11bb33dd", MonDReg);
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] rd;
    int cyc;
    logic done;
    done = 1'b0;
    rd = 'x;
    jtag_op(1, 0, 0, jaddr(8'h10, 0, 0));
    address = 9'h010; byteenable = 4'hF; debugaccess = 1'b1;
    chipselect = 1'b1; read = 1'b1; write = 1'b0;
    take_no_action_ocimem_a = 1'b1;
    @(posedge clk);
    #1;
    take_no_action_ocimem_a = 1'b0;
    cyc = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (!waitrequest) begin
        rd = readdata;
        done = 1'b1;
        break;
      end
    end
    checks++;
    if ({done, rd, cyc[7:0], MonDReg, dut.mon_areg} !== {1'b1, 32'hDEADBEEF, 8'd6, 32'hDEADBEEF, 8'h11}) begin
      errors++;
      $display("FAIL concurrent: done=%b rd=%h cycles=%0d MonDReg=%h areg=%h, required 1 deadbeef 6 deadbeef 11",
               done, rd, cyc, MonDReg, dut.mon_areg);
    end
    @(posedge clk);
    #1;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] rd;
    int cyc;
    jtag_op(1, 0, 0, jaddr(8'h20, 0, 0));
    jtag_op(0, 0, 1, '0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(2);
    checks++;
    if ({MonDReg, dut.mon_areg, waitrequest} !== {32'h0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_read: MonDReg=%h areg=%h wait=%b, required 0 00 1", MonDReg, dut.mon_areg, waitrequest);
    end
    cpu_access(0, 9'h020, '0, 4'hF, 1, rd, cyc);
    checks++;
    if ({rd, cyc[7:0]} !== {32'h11BB33DD, 8'd3}) begin
      errors++;
      $display("FAIL read_after_reset: data=%h cycles=%0d, required 11bb33dd 3", rd, cyc);
    end
  endtask

  task automatic test_write_protect();
    logic [31:0] rd, exp_ram;
    logic exp_rdy;
    int cyc;
`ifdef OCI_MEM_WRITE_PROTECT_EN
    exp_ram = 32'h0;
    exp_rdy = 1'b0;
`else
    exp_ram = 32'h12345678;
    exp_rdy = 1'b1;
`endif
    cpu_access(1, 9'h030, 32'h0, 4'hF, 1, rd, cyc);
    cpu_access(1, 9'h030, 32'h12345678, 4'hF, 0, rd, cyc);
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("FAIL wp_handshake: cycles=%0d, required 3", cyc);
    end
    cpu_access(0, 9'h030, '0, 4'hF, 0, rd, cyc);
    checks++;
    if (rd !== exp_ram) begin
      errors++;
      $display("FAIL wp_ram_da0: data=%h, required %h", rd, exp_ram);
    end
    cpu_access(1, 9'h030, 32'h12345678, 4'hF, 1, rd, cyc);
    cpu_access(0, 9'h030, '0, 4'hF, 0, rd, cyc);
    checks++;
    if (rd !== 32'h12345678) begin
      errors++;
      $display("FAIL wp_ram_da1: data=%h, required 12345678", rd);
    end
    cpu_access(1, 9'h100, 32'h1, 4'h0, 0, rd, cyc);
    checks++;
    if (monitor_ready !== exp_rdy) begin
      errors++;
      $display("FAIL wp_ctrl_da0: ready=%b, required %b", monitor_ready, exp_rdy);
    end
  endtask

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    writedata = '0; byteenable = '0; debugaccess = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);
    test_reset();
    test_addr_load();
    test_jtag_rw();
    test_wrap();
    test_priority();
    test_ctrl();
    test_byteenable();
    test_concurrent();
    test_reset_mid_read();
    test_write_protect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
